traffic_enable_gen: RTL and testbench

TRAFFIC_ENABLE_GEN -- requirements
Module: traffic_enable_gen

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/sw_debounce.sv | 47 ++++
 rtl/traffic_enable_gen.sv | 104 ++++++++++
 tb/tb_traffic_enable_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings and defaults for the traffic enable generator.
// Also holds the prescaler terminal-count helper used by the top level.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int TICK_DIV_DEF = 4;
   localparam int DEB_LEN_DEF  = 3;

   // Bit positions of the raw switch/button vector fed to the debouncers
   localparam int NUM_SW   = 4;
   localparam int SW_RUN   = 0;
   localparam int SW_HOLD  = 1;
   localparam int SW_PED_L = 2;
   localparam int SW_PED_R = 3;

   // Terminal count for the prescaler; a pending request halves the period (floor 1)
   function automatic logic [7:0] term_count(input int tick_div, input logic short_i);
      int div;
      if (short_i) div = (tick_div / 2 > 1) ? tick_div / 2 : 1;
      else         div = tick_div;
      return 8'(div - 1);
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw switch.
// deb_o is the value the debounced flop takes at the next edge.
module sw_debounce
   import traffic_pkg::*;
#(
   parameter int DEB_LEN = DEB_LEN_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic deb_o
);

   localparam logic [3:0] CNT_LAST = 4'(DEB_LEN - 1);

   logic       sync1_q, sync2_q;
   logic       deb_q, deb_d;
   logic [3:0] cnt_q, cnt_d;

   // Any sample matching the accepted value restarts the stability count
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) deb_d = sync2_q;
         else                   cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Exposing the next value lets consumers update on the same edge as deb_q
   assign deb_o = deb_d;

endmodule

// File: rtl/traffic_enable_gen.sv
// Run/hold sequencer producing periodic ENABLE pulses for a light controller,
// with latched pedestrian requests that shorten the pulse period.
module traffic_enable_gen
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int DEB_LEN  = DEB_LEN_DEF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       run_sw_i,
   input  logic       hold_sw_i,
   input  logic       ped_btn_l_i,
   input  logic       ped_btn_r_i,
   input  logic       ped_ack_l_i,
   input  logic       ped_ack_r_i,
   output logic       enable_o,
   output logic       ped_req_l_o,
   output logic       ped_req_r_o,
   output logic [1:0] state_o
);

   localparam logic [7:0] TC_FULL  = term_count(TICK_DIV, 1'b0);
   localparam logic [7:0] TC_SHORT = term_count(TICK_DIV, 1'b1);

   logic [NUM_SW-1:0] sw_raw, sw_deb;
   logic              run_deb, hold_deb;
   logic [1:0]        btn_deb, btn_prev_q, btn_rise;
   logic [1:0]        ped_ack, req_q, req_d;
   state_e            state_q, state_d;
   logic [7:0]        presc_q, presc_d, tc;
   logic              fire;

   assign sw_raw = {ped_btn_r_i, ped_btn_l_i, hold_sw_i, run_sw_i};

   for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
      sw_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .raw_i   (sw_raw[g]),
         .deb_o   (sw_deb[g])
      );
   end

   assign run_deb  = sw_deb[SW_RUN];
   assign hold_deb = sw_deb[SW_HOLD];
   assign btn_deb  = {sw_deb[SW_PED_R], sw_deb[SW_PED_L]};
   assign btn_rise = btn_deb & ~btn_prev_q;
   assign ped_ack  = {ped_ack_r_i, ped_ack_l_i};

   // A fresh press outranks a same-cycle acknowledge
   assign req_d = btn_rise | (req_q & ~ped_ack);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (run_deb) state_d = ST_RUN;
         ST_RUN: begin
            if (!run_deb)     state_d = ST_IDLE;
            else if (hold_deb) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!run_deb)      state_d = ST_IDLE;
            else if (!hold_deb) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tc   = (req_q != 2'b00) ? TC_SHORT : TC_FULL;
   assign fire = !reset_i && (state_q == ST_RUN) && (state_d == ST_RUN) && (presc_q >= tc);

   // Prescaler only counts while staying in RUN; entering RUN from HOLD resumes the frozen value
   always_comb begin
      presc_d = presc_q;
      case (state_d)
         ST_IDLE: presc_d = '0;
         ST_RUN: begin
            if (state_q == ST_RUN) presc_d = fire ? 8'd0 : presc_q + 8'd1;
         end
         default: presc_d = presc_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         req_q      <= '0;
         btn_prev_q <= '0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         req_q      <= req_d;
         btn_prev_q <= btn_deb;
      end
   end

   assign enable_o    = fire;
   assign ped_req_l_o = req_q[0];
   assign ped_req_r_o = req_q[1];
   assign state_o     = state_q;

endmodule

// File: tb/tb_traffic_enable_gen.sv
// Directed bench: a per-cycle vector table for the main run/ped/hold flow,
// then hand sequences for glitch rejection, press/ack collision and mid-run reset.
module tb_traffic_enable_gen;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam int NSEG = 28;

   typedef struct {
      int         n;
      logic       run, hold, bl, br, al, ar;
      logic [1:0] st;
      logic       en, rl, rr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, run, hold, bl, br, al, ar;
   logic       en, rl, rr;
   logic [1:0] st;
   int         total = 0;
   int         bad = 0;
   vec_t       tbl [NSEG];

   traffic_enable_gen #(.TICK_DIV(4), .DEB_LEN(3)) dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .run_sw_i    (run),
      .hold_sw_i   (hold),
      .ped_btn_l_i (bl),
      .ped_btn_r_i (br),
      .ped_ack_l_i (al),
      .ped_ack_r_i (ar),
      .enable_o    (en),
      .ped_req_l_o (rl),
      .ped_req_r_o (rr),
      .state_o     (st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic h, input logic b_l, input logic b_r,
                        input logic a_l, input logic a_r);
      run = r; hold = h; bl = b_l; br = b_r; al = a_l; ar = a_r;
   endtask

   // Leaves the bench mid-cycle right after the last reset edge, reset released
   task automatic do_reset();
      rst = 1'b1;
      drive(L, L, L, L, L, L);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tbl = '{
         '{5, H,L,L,L,L,L, S0, L,L,L},
         '{3, H,L,L,L,L,L, S1, L,L,L},
         '{1, H,L,L,L,L,L, S1, H,L,L},
         '{3, H,L,L,L,L,L, S1, L,L,L},
         '{1, H,L,L,L,L,L, S1, H,L,L},
         '{3, H,L,H,L,L,L, S1, L,L,L},
         '{1, H,L,H,L,L,L, S1, H,L,L},
         '{1, H,L,H,L,L,L, S1, L,L,L},
         '{1, H,L,H,L,L,L, S1, H,H,L},
         '{1, H,L,H,L,L,L, S1, L,H,L},
         '{1, H,L,H,L,L,L, S1, H,H,L},
         '{1, H,L,H,L,L,L, S1, L,H,L},
         '{1, H,L,H,L,L,L, S1, H,H,L},
         '{1, H,L,L,L,L,L, S1, L,H,L},
         '{1, H,L,L,L,L,L, S1, H,H,L},
         '{1, H,L,L,L,H,L, S1, L,H,L},
         '{2, H,L,L,L,L,L, S1, L,L,L},
         '{1, H,L,L,L,L,L, S1, H,L,L},
         '{2, H,L,L,L,L,L, S1, L,L,L},
         '{1, H,H,L,L,L,L, S1, L,L,L},
         '{1, H,H,L,L,L,L, S1, H,L,L},
         '{3, H,H,L,L,L,L, S1, L,L,L},
         '{4, H,H,L,L,L,L, S2, L,L,L},
         '{5, H,L,L,L,L,L, S2, L,L,L},
         '{1, H,L,L,L,L,L, S1, L,L,L},
         '{1, H,L,L,L,L,L, S1, H,L,L},
         '{3, H,L,L,L,L,L, S1, L,L,L},
         '{1, H,L,L,L,L,L, S1, H,L,L}
      };

      // Reset state, checked while reset is still asserted
      rst = 1'b1;
      drive(L, L, L, L, L, L);
      repeat (2) @(negedge clk);
      #1;
      chk("rst state", 8'(st), 8'd0);
      chk("rst enable", 8'(en), 8'd0);
      chk("rst req_l", 8'(rl), 8'd0);
      chk("rst req_r", 8'(rr), 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Main flow: start, ped request shortens period, ack, hold with prescaler at 2
      for (int s = 0; s < NSEG; s++) begin
         for (int k = 0; k < tbl[s].n; k++) begin
            drive(tbl[s].run, tbl[s].hold, tbl[s].bl, tbl[s].br, tbl[s].al, tbl[s].ar);
            #1;
            chk($sformatf("tbl%0d.%0d state", s, k), 8'(st), 8'(tbl[s].st));
            chk($sformatf("tbl%0d.%0d enable", s, k), 8'(en), 8'(tbl[s].en));
            chk($sformatf("tbl%0d.%0d req_l", s, k), 8'(rl), 8'(tbl[s].rl));
            chk($sformatf("tbl%0d.%0d req_r", s, k), 8'(rr), 8'(tbl[s].rr));
            @(negedge clk);
         end
      end

      // Run switch glitch shorter than the debounce window is ignored
      do_reset();
      for (int t = 0; t < 12; t++) begin
         drive((t < 2) ? H : L, L, L, L, L, L);
         #1;
         chk($sformatf("glitch%0d state", t), 8'(st), 8'd0);
         chk($sformatf("glitch%0d enable", t), 8'(en), 8'd0);
         @(negedge clk);
      end

      // Right request latches in IDLE; re-press edge coinciding with ack keeps it set
      do_reset();
      for (int t = 0; t < 18; t++) begin
         drive(L, L, L, ((t < 6) || (t >= 11)) ? H : L, L, ((t == 15) || (t == 16)) ? H : L);
         #1;
         if (t == 4)  chk("pedr before", 8'(rr), 8'd0);
         if (t == 5)  chk("pedr set", 8'(rr), 8'd1);
         if (t == 10) chk("pedr held", 8'(rr), 8'd1);
         if (t == 15) chk("pedr edge+ack", 8'(rr), 8'd1);
         if (t == 16) chk("pedr set wins", 8'(rr), 8'd1);
         if (t == 17) chk("pedr cleared", 8'(rr), 8'd0);
         if (t == 17) chk("pedr idle state", 8'(st), 8'd0);
         if (t == 17) chk("pedr idle enable", 8'(en), 8'd0);
         @(negedge clk);
      end

      // Request arriving past the short terminal count fires at once; then a one-cycle reset
      do_reset();
      for (int t = 0; t < 17; t++) begin
         drive(H, L, ((t >= 2) && (t <= 5)) ? H : L, L, L, L);
         rst = (t == 9);
         #1;
         if (t == 5)  chk("mid run state", 8'(st), 8'd1);
         if (t == 6)  chk("mid no req en", 8'(en), 8'd0);
         if (t == 6)  chk("mid no req", 8'(rl), 8'd0);
         if (t == 7)  chk("mid late req", 8'(rl), 8'd1);
         if (t == 7)  chk("mid late fire", 8'(en), 8'd1);
         if (t == 8)  chk("mid after fire", 8'(en), 8'd0);
         if (t == 9)  chk("rst cycle en", 8'(en), 8'd0);
         if (t == 10) chk("post rst state", 8'(st), 8'd0);
         if (t == 10) chk("post rst en", 8'(en), 8'd0);
         if (t == 10) chk("post rst req_l", 8'(rl), 8'd0);
         if (t == 14) chk("redeb state", 8'(st), 8'd0);
         if (t == 15) chk("resume state", 8'(st), 8'd1);
         if (t == 15) chk("resume en", 8'(en), 8'd0);
         @(negedge clk);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
